// File: rtl/psu_issue_ctrl_pkg.sv
// Shared widths, opcode sentinel and FSM encodings for the PSU issue sequencer.
package psu_issue_ctrl_pkg;
  localparam int OPCODE_BW  = 4;
  localparam int PCHINFO_BW = 16;
  localparam int PCHADDR_BW = 8;

  localparam logic [OPCODE_BW-1:0] INVALID_OPCODE = '1;

  typedef enum logic [1:0] {
    PSUISS_IDLE  = 2'd0,
    PSUISS_FETCH = 2'd1,
    PSUISS_SEND  = 2'd2
  } psuiss_state_e;
endpackage

// File: rtl/psu_issue_ctrl_credit.sv
// Credit counter for opcodes outstanding in PSU: consumes on issue completion,
// returns on op_done, saturates at CREDITS and flags a sticky error on over-return.
module psu_issue_credit #(
  parameter int CREDITS = 2,
  parameter int CRED_BW = 2
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               dec,
  input  logic               inc,
  output logic [CRED_BW-1:0] credits,
  output logic               has_credit,
  output logic               credit_err
);
  localparam logic [CRED_BW-1:0] FULL = CRED_BW'(CREDITS);

  always_ff @(posedge clk) begin
    if (rst) begin
      credits    <= FULL;
      credit_err <= 1'b0;
    end else begin
      // A coincident consume and return cancel out.
      case ({dec, inc})
        2'b10: if (credits != '0) credits <= credits - 1'b1;
        2'b01: begin
          if (credits == FULL) credit_err <= 1'b1;
          else                 credits    <= credits + 1'b1;
        end
        default: ;
      endcase
    end
  end

  assign has_credit = (credits != '0);
endmodule

// File: rtl/psu_issue_ctrl.sv
// Issue sequencer in front of PSU: fetches pchinfo per patch from the PIT and streams beats.
// Optional stall counter enabled by defining PSU_ISSUE_PERF_EN.
module psu_issue_ctrl
  import psu_issue_ctrl_pkg::*;
#(
  parameter int CREDITS = 2,
  parameter int CRED_BW = 2,
  parameter int PERF_BW = 16
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  inst_valid,
  output logic                  inst_ready,
  input  logic [OPCODE_BW-1:0]  inst_opcode,
  input  logic [PCHADDR_BW-1:0] inst_pch_base,
  input  logic [PCHADDR_BW-1:0] inst_pch_last,
  output logic                  pit_rd_en,
  output logic [PCHADDR_BW-1:0] pit_rd_addr,
  input  logic [PCHINFO_BW-1:0] pit_rd_data,
  output logic                  topsu_valid,
  output logic [OPCODE_BW-1:0]  opcode_out,
  output logic [PCHINFO_BW-1:0] pchinfo_out,
  output logic                  last_pchinfo,
  input  logic                  pchwr_stall,
  input  logic                  op_done,
  output logic                  busy,
  output logic                  credit_err,
  output logic [PERF_BW-1:0]    stall_cnt,
  output logic [1:0]            state_dbg,
  output logic [CRED_BW-1:0]    credits_dbg
);
  // Handshakes: an instruction moves when inst_valid & inst_ready; a beat moves
  // when topsu_valid & ~pchwr_stall, and the beat is held unchanged until then.
  localparam logic [PCHADDR_BW-1:0] ONE_ADDR = PCHADDR_BW'(1);
  localparam logic [CRED_BW-1:0]    FULL     = CRED_BW'(CREDITS);

  psuiss_state_e         state;
  logic [PCHADDR_BW-1:0] base_q;
  logic [PCHADDR_BW-1:0] last_q;
  logic [PCHADDR_BW-1:0] idx_q;
  logic [CRED_BW-1:0]    credits;
  logic                  has_credit;
  logic                  inst_acc;
  logic                  beat_acc;
  logic                  last_acc;
  logic                  next_fetch;

  assign inst_ready = (state == PSUISS_IDLE) && has_credit;
  assign inst_acc   = inst_ready && inst_valid;
  assign beat_acc   = (state == PSUISS_SEND) && !pchwr_stall;
  assign last_acc   = beat_acc && last_pchinfo;
  assign next_fetch = beat_acc && !last_pchinfo;

  // The next PIT read overlaps the accepting cycle so data lands in FETCH.
  assign pit_rd_en   = inst_acc || next_fetch;
  assign pit_rd_addr = (state == PSUISS_IDLE) ? inst_pch_base : base_q + idx_q + ONE_ADDR;

  assign busy        = (state != PSUISS_IDLE) || (credits != FULL);
  assign state_dbg   = state;
  assign credits_dbg = credits;

  always_ff @(posedge clk) begin
    if (rst) begin
      state        <= PSUISS_IDLE;
      base_q       <= '0;
      last_q       <= '0;
      idx_q        <= '0;
      topsu_valid  <= 1'b0;
      opcode_out   <= INVALID_OPCODE;
      pchinfo_out  <= '0;
      last_pchinfo <= 1'b0;
    end else begin
      case (state)
        PSUISS_IDLE: begin
          if (inst_acc) begin
            opcode_out <= inst_opcode;
            base_q     <= inst_pch_base;
            last_q     <= inst_pch_last;
            idx_q      <= '0;
            state      <= PSUISS_FETCH;
          end
        end
        PSUISS_FETCH: begin
          pchinfo_out  <= pit_rd_data;
          topsu_valid  <= 1'b1;
          last_pchinfo <= (idx_q == last_q);
          state        <= PSUISS_SEND;
        end
        PSUISS_SEND: begin
          if (beat_acc) begin
            topsu_valid <= 1'b0;
            if (last_pchinfo) begin
              state <= PSUISS_IDLE;
            end else begin
              idx_q <= idx_q + ONE_ADDR;
              state <= PSUISS_FETCH;
            end
          end
        end
        default: state <= PSUISS_IDLE;
      endcase
    end
  end

  psu_issue_credit #(
    .CREDITS (CREDITS),
    .CRED_BW (CRED_BW)
  ) u_credit (
    .clk        (clk),
    .rst        (rst),
    .dec        (last_acc),
    .inc        (op_done),
    .credits    (credits),
    .has_credit (has_credit),
    .credit_err (credit_err)
  );

`ifdef PSU_ISSUE_PERF_EN
  always_ff @(posedge clk) begin
    if (rst) begin
      stall_cnt <= '0;
    end else if (topsu_valid && pchwr_stall && (stall_cnt != '1)) begin
      stall_cnt <= stall_cnt + 1'b1;
    end
  end
`else
  assign stall_cnt = '0;
`endif
endmodule
